mux_result_packer: RTL and testbench
====================================

MUX_RESULT_PACKER -- requirements
Module: mux_result_packer

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit results packed per output word; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 Y_in  input  4  result nibble from the upstream mux FSM.
REQ-005 data_enable  input  1  single-cycle qualifier; high means Y_in is valid this cycle. Driven by the upstream output_enable.
REQ-006 clear  input  1  synchronous flush of all state.
REQ-007 word_out  output  4*NIBBLES  packed word; nibble k occupies bits [4k+3:4k].
REQ-008 word_valid  output  1  word_out holds an unconsumed word.
REQ-009 word_ready  input  1  downstream accepts word_out when high together with word_valid.
REQ-010 nibble_count  output  3  nibbles currently held in the assembly register, 0..NIBBLES-1.
REQ-011 overflow  output  1  sticky flag; set when a completed word is dropped.

Function
REQ-012 Assembly register and output register are separate, so collection continues while a word waits downstream.
REQ-013 On data_enable, Y_in is written to nibble slot nibble_count; the first nibble after empty goes to bits [3:0].
REQ-014 nibble_count increments by 1 on each accepted nibble and wraps to 0 when slot NIBBLES-1 is written (word complete).
REQ-015 Output state machine has two states.
  - EMPTY: word_valid=0.
  - FULL: word_valid=1.
REQ-016 Transfer occurs when word_valid=1 and word_ready=1; word_out is then considered consumed.
REQ-017 Word complete with output EMPTY: the assembled word loads into word_out and word_valid goes 1 on the next edge. Latency from last nibble to word_valid is 1 cycle.
REQ-018 Word complete with output FULL and a transfer in the same cycle: the new word loads and word_valid stays 1. No bubble, no overflow.
REQ-019 Word complete with output FULL and no transfer: word_out and word_valid are unchanged. The completed word is discarded, overflow is set, and nibble_count still wraps to 0.
REQ-020 Transfer with no word completing: the state machine goes FULL->EMPTY on the next edge.
REQ-021 word_out shall remain stable while word_valid=1 and no transfer occurs.
REQ-022 Slots of the assembly register not yet written in the current word are zero.
REQ-023 clear=1 has priority over data_enable and word_ready. On the next edge:
  - nibble_count=0 and the assembly register is zeroed;
  - word_valid=0 and word_out=0;
  - overflow=0.
REQ-024 data_enable high on consecutive cycles shall be accepted every cycle; no back-pressure is exerted upstream.

Reset
REQ-025 Asserting rst (low) immediately forces:
  - word_out=0, word_valid=0, nibble_count=0, overflow=0;
  - assembly register=0;
  - state EMPTY.
REQ-026 Reset mid-word discards the partial word. The first data_enable after release writes slot 0.
REQ-027 Reset is released synchronously to the design (deassertion sampled on posedge clk).

Configuration
REQ-028 Macro PACKER_PARITY_EN, when defined, adds output port word_parity (1 bit). word_parity is the XOR of all word_out bits, registered together with word_out and reset to 0.
REQ-029 Without PACKER_PARITY_EN, the word_parity port and its logic are absent; all other behaviour is identical.

Verification
REQ-030 Reset, then NIBBLES=4 with word_ready=1; feed 0x1,0x2,0x3,0x4 on spaced data_enable pulses. Required: word_out=0x4321 and word_valid high 1 cycle after the fourth nibble, cleared the cycle after.
REQ-031 word_ready=0; feed 8 nibbles 0x1..0x8. Required: word_out stays 0x4321, overflow=1 after the 8th nibble, nibble_count=0.
REQ-032 word_valid=1 with 0x4321 held; raise word_ready in the same cycle the next word 0x8765 completes. Required: word_valid stays 1, word_out=0x8765, overflow=0.
REQ-033 Feed 2 nibbles, then pulse clear together with data_enable. Required: nibble_count=0, word_valid=0, next nibble lands in bits [3:0].
REQ-034 Feed 3 nibbles, assert rst low mid-cycle. Required: all outputs 0 immediately. After release, 0xA,0xB,0xC,0xD yields 0xDCBA.
REQ-035 With PACKER_PARITY_EN defined, word 0x0007 yields word_parity=1 and word 0x0003 yields word_parity=0.

Source files
------------

// File: rtl/mux_result_packer.sv
// mux_result_packer: collects 4-bit results from the upstream mux FSM into
// NIBBLES-wide words and hands them downstream over a valid/ready port.
// The assembly register keeps collecting while a finished word waits in the
// output register. A word that completes while the output is still occupied
// and not being consumed is dropped, and the sticky overflow flag is raised.
// Optional feature: define PACKER_PARITY_EN to add the word_parity output
// (XOR of all word_out bits, registered alongside word_out).
module mux_result_packer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             Y_in,
    input  logic                   data_enable,
    input  logic                   clear,
    output logic [4*NIBBLES-1:0]   word_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [2:0]             nibble_count,
    output logic                   overflow
`ifdef PACKER_PARITY_EN
    ,
    output logic                   word_parity
`endif
);

    localparam int         W    = 4 * NIBBLES;
    localparam logic [2:0] LAST = 3'(NIBBLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   asm_reg;
    logic [W-1:0]   asm_next;
    logic [W-1:0]   word_done;
    logic [2:0]     count_next;
    logic           complete;
    logic           transfer;
    logic           load;
    logic           drop;

    // Assembly register with the incoming nibble dropped into its slot.
    always_comb begin
        word_done = asm_reg;
        for (int k = 0; k < NIBBLES; k++) begin
            if (nibble_count == 3'(k)) begin
                word_done[4*k +: 4] = Y_in;
            end
        end
    end

    assign complete   = data_enable && (nibble_count == LAST);
    assign transfer   = (state == FULL) && word_ready;
    assign load       = complete && ((state == EMPTY) || transfer);
    assign drop       = complete && (state == FULL) && !transfer;
    assign word_valid = (state == FULL);

    // Next assembly contents: completed words leave zeros behind so that
    // unwritten slots of the next word read as zero.
    always_comb begin
        asm_next   = asm_reg;
        count_next = nibble_count;
        if (data_enable) begin
            if (complete) begin
                asm_next   = '0;
                count_next = 3'd0;
            end else begin
                asm_next   = word_done;
                count_next = nibble_count + 3'd1;
            end
        end
    end

    // Output FSM next state: a load keeps or makes it FULL, a bare transfer empties it.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (load) state_next = FULL;
            FULL:  if (transfer && !load) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (clear) state_next = EMPTY;
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_next;
    end

    // Assembly register and slot counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_reg      <= '0;
            nibble_count <= 3'd0;
        end else if (clear) begin
            asm_reg      <= '0;
            nibble_count <= 3'd0;
        end else begin
            asm_reg      <= asm_next;
            nibble_count <= count_next;
        end
    end

    // Output word register: only loads when the word is actually accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       word_out <= '0;
        else if (clear) word_out <= '0;
        else if (load)  word_out <= word_done;
    end

    // Sticky overflow flag, raised when a completed word has nowhere to go.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       overflow <= 1'b0;
        else if (clear) overflow <= 1'b0;
        else if (drop)  overflow <= 1'b1;
    end

`ifdef PACKER_PARITY_EN
    // Parity tracks word_out exactly, loaded on the same condition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       word_parity <= 1'b0;
        else if (clear) word_parity <= 1'b0;
        else if (load)  word_parity <= ^word_done;
    end
`endif

endmodule

// File: tb/tb_mux_result_packer.sv
// Self-checking bench for mux_result_packer (NIBBLES=4). Expected words are
// pushed into a scoreboard queue by a nibble-list reference model; a monitor
// on the falling edge compares the DUT against the model and pops on transfer.
module tb_mux_result_packer;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [3:0]     Y_in;
    logic           data_enable;
    logic           clear;
    logic [4*N-1:0] word_out;
    logic           word_valid;
    logic           word_ready;
    logic [2:0]     nibble_count;
    logic           overflow;
`ifdef PACKER_PARITY_EN
    logic           word_parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [3:0]  nibs[$];
    logic [31:0] sbq[$];
    logic        m_full = 1'b0;
    logic        m_ovf  = 1'b0;

    mux_result_packer #(.NIBBLES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .Y_in         (Y_in),
        .data_enable  (data_enable),
        .clear        (clear),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .nibble_count (nibble_count),
        .overflow     (overflow)
`ifdef PACKER_PARITY_EN
        ,
        .word_parity  (word_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        nibs.delete();
        sbq.delete();
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    // One clock of the packer's rules, applied to the inputs of that cycle.
    function automatic void model_step(input logic d, input logic [3:0] y,
                                       input logic r, input logic c);
        logic        tr;
        logic        loaded;
        logic [31:0] w;
        if (c) begin
            model_reset();
            return;
        end
        tr     = m_full && r;
        loaded = 1'b0;
        if (d) begin
            nibs.push_back(y);
            if (nibs.size() == N) begin
                w = 32'd0;
                foreach (nibs[i]) w = w + (32'(nibs[i]) << (4 * i));
                nibs.delete();
                if (!m_full || tr) begin
                    sbq.push_back(w);
                    loaded = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (loaded)  m_full = 1'b1;
        else if (tr) m_full = 1'b0;
    endfunction

    task automatic cyc(input logic d, input logic [3:0] y, input logic r, input logic c);
        data_enable = d;
        Y_in        = y;
        word_ready  = r;
        clear       = c;
        @(posedge clk);
        model_step(d, y, r, c);
        #1;
    endtask

    task automatic feed(input logic [3:0] y, input logic r);
        cyc(1'b1, y, r, 1'b0);
    endtask

    // Monitor: compare state every cycle, check and retire words on handshake.
    always @(negedge clk) begin
        chk("valid", 32'(word_valid), 32'(m_full));
        chk("nibble_count", 32'(nibble_count), 32'(nibs.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (word_valid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_word: word_valid=1 but no expected word at %0t", $time);
            end else begin
                chk("sb_word", 32'(word_out), sbq[0]);
`ifdef PACKER_PARITY_EN
                chk("sb_parity", 32'(word_parity), 32'(^sbq[0]));
`endif
                if (word_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        Y_in = 4'h0;
        data_enable = 1'b0;
        clear = 1'b0;
        word_ready = 1'b0;
        #1;
        chk("reset_word", 32'(word_out), 32'h0);
        chk("reset_valid", 32'(word_valid), 32'h0);
        chk("reset_count", 32'(nibble_count), 32'h0);
        chk("reset_ovf", 32'(overflow), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // spaced nibbles, ready high
        for (int i = 1; i <= 4; i++) begin
            feed(4'(i), 1'b1);
            if (i == 3) chk("count_3", 32'(nibble_count), 32'd3);
            cyc(1'b0, 4'h0, 1'b1, 1'b0);
            if (i == 4) chk("d30_valid_cleared", 32'(word_valid), 32'd0);
        end

        // redo so the completion edge itself can be checked
        for (int i = 1; i <= 4; i++) feed(4'(i), 1'b1);
        chk("d30_valid", 32'(word_valid), 32'd1);
        chk("d30_word", 32'(word_out), 32'h4321);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        chk("d30_after", 32'(word_valid), 32'd0);

        // ready low: second word dropped
        for (int i = 1; i <= 8; i++) feed(4'(i), 1'b0);
        chk("d31_word", 32'(word_out), 32'h4321);
        chk("d31_ovf", 32'(overflow), 32'd1);
        chk("d31_count", 32'(nibble_count), 32'd0);
        chk("d31_valid", 32'(word_valid), 32'd1);

        // back-to-back: transfer in the completion cycle
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("clr_valid", 32'(word_valid), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_word", 32'(word_out), 32'd0);
        for (int i = 1; i <= 7; i++) feed(4'(i), 1'b0);
        feed(4'h8, 1'b1);
        chk("d32_valid", 32'(word_valid), 32'd1);
        chk("d32_word", 32'(word_out), 32'h8765);
        chk("d32_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // clear together with data_enable
        feed(4'h1, 1'b0);
        feed(4'h2, 1'b0);
        cyc(1'b1, 4'h5, 1'b0, 1'b1);
        chk("d33_count", 32'(nibble_count), 32'd0);
        chk("d33_valid", 32'(word_valid), 32'd0);
        feed(4'h9, 1'b1);
        feed(4'h2, 1'b1);
        feed(4'h3, 1'b1);
        feed(4'h4, 1'b1);
        chk("d33_word", 32'(word_out), 32'h4329);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // asynchronous reset mid-word with a word held
        for (int i = 1; i <= 4; i++) feed(4'(i), 1'b0);
        for (int i = 1; i <= 3; i++) feed(4'(i), 1'b0);
        data_enable = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("d34_word", 32'(word_out), 32'h0);
        chk("d34_valid", 32'(word_valid), 32'h0);
        chk("d34_count", 32'(nibble_count), 32'h0);
        chk("d34_ovf", 32'(overflow), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        feed(4'hA, 1'b1);
        feed(4'hB, 1'b1);
        feed(4'hC, 1'b1);
        feed(4'hD, 1'b1);
        chk("d34_new_word", 32'(word_out), 32'hDCBA);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);

`ifdef PACKER_PARITY_EN
        feed(4'h7, 1'b0);
        for (int i = 0; i < 3; i++) feed(4'h0, 1'b0);
        chk("parity_7", 32'(word_parity), 32'd1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        feed(4'h3, 1'b0);
        for (int i = 0; i < 3; i++) feed(4'h0, 1'b0);
        chk("parity_3", 32'(word_parity), 32'd0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
`endif

        // randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 99) < 65, 4'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) < 2);
        end
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
